// File: rtl/ycbcr_keyer_pkg.sv
// Shared encodings and bound types for the YCbCr chroma keyer.
// Bounds are stored at MAX_DATA_W and zero-extended, so one struct serves any DATA_W up to 16.
package ycbcr_keyer_pkg;

    localparam int MAX_DATA_W = 16;

    typedef enum logic [2:0] {
        SEL_Y_LO  = 3'd0,
        SEL_Y_HI  = 3'd1,
        SEL_CB_LO = 3'd2,
        SEL_CB_HI = 3'd3,
        SEL_CR_LO = 3'd4,
        SEL_CR_HI = 3'd5
    } cfg_sel_e;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_BG   = 2'd1,
        MODE_FILL = 2'd2,
        MODE_MASK = 2'd3
    } mode_e;

    typedef logic [MAX_DATA_W-1:0] bound_t;

    typedef struct packed {
        bound_t lo;
        bound_t hi;
    } range_t;

    typedef struct packed {
        range_t y;
        range_t cb;
        range_t cr;
    } win_bounds_t;

    // Inclusive unsigned test; an inverted range (lo > hi) can never hold.
    function automatic logic in_range(input bound_t v, input range_t r);
        return (v >= r.lo) && (v <= r.hi);
    endfunction

endpackage

// File: rtl/keyer_window_cmp.sv
// One key window: six programmable bound registers, their write decode,
// and a registered match flag for the pixel presented this cycle.
module keyer_window_cmp
    import ycbcr_keyer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int WIN_IDX = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_win,
    input  logic [2:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] cb,
    input  logic [DATA_W-1:0] cr,
    output logic              match
);

    localparam bound_t HI_RESET = bound_t'((64'd1 << DATA_W) - 64'd1);
    localparam win_bounds_t BOUNDS_RESET = '{
        y:  '{lo: '0, hi: HI_RESET},
        cb: '{lo: '0, hi: HI_RESET},
        cr: '{lo: '0, hi: HI_RESET}
    };

    win_bounds_t bounds;
    bound_t      wr_val;
    logic        wr_hit;

    assign wr_val = bound_t'(cfg_data);
    assign wr_hit = cfg_we && (cfg_win == 3'(WIN_IDX));

    // NOTE: the bounds are plain flops, not a RAM, so they take a reset value
    // and sit in the async-reset branch like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounds <= BOUNDS_RESET;
        end else if (wr_hit) begin
            case (cfg_sel_e'(cfg_sel))
                SEL_Y_LO:  bounds.y.lo  <= wr_val;
                SEL_Y_HI:  bounds.y.hi  <= wr_val;
                SEL_CB_LO: bounds.cb.lo <= wr_val;
                SEL_CB_HI: bounds.cb.hi <= wr_val;
                SEL_CR_LO: bounds.cr.lo <= wr_val;
                SEL_CR_HI: bounds.cr.hi <= wr_val;
                default:   ;
            endcase
        end
    end

    // NOTE: non-blocking here so a same-edge write is not seen by this compare;
    // the pixel sampled on the write edge still uses the old bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= in_range(bound_t'(y),  bounds.y)  &&
                     in_range(bound_t'(cb), bounds.cb) &&
                     in_range(bound_t'(cr), bounds.cr);
        end
    end

endmodule

// File: rtl/ycbcr_chroma_keyer.sv
// Chroma-key compositor: window compare (stage 1), key/mode mux (stage 2),
// and a per-frame keyed-pixel counter closed by the rising edge of iVS.
module ycbcr_chroma_keyer
    import ycbcr_keyer_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               RGB_W   = 10,
    parameter int               NUM_WIN = 2,
    parameter int               COUNT_W = 20,
    parameter logic [RGB_W-1:0] FILL_R  = 10'h3FF,
    parameter logic [RGB_W-1:0] FILL_G  = 10'h190,
    parameter logic [RGB_W-1:0] FILL_B  = 10'h050
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iCfg_WE,
    input  logic [2:0]         iCfg_Win,
    input  logic [2:0]         iCfg_Sel,
    input  logic [DATA_W-1:0]  iCfg_Data,
    input  logic [NUM_WIN-1:0] iWin_En,
    input  logic               iInvert,
    input  logic [1:0]         iMode,
    input  logic               iVS,
    input  logic               iDVAL,
    input  logic [DATA_W-1:0]  iY,
    input  logic [DATA_W-1:0]  iCb,
    input  logic [DATA_W-1:0]  iCr,
    input  logic [RGB_W-1:0]   iRed,
    input  logic [RGB_W-1:0]   iGreen,
    input  logic [RGB_W-1:0]   iBlue,
    input  logic [RGB_W-1:0]   iBg_R,
    input  logic [RGB_W-1:0]   iBg_G,
    input  logic [RGB_W-1:0]   iBg_B,
    output logic               oDVAL,
    output logic [RGB_W-1:0]   oRed,
    output logic [RGB_W-1:0]   oGreen,
    output logic [RGB_W-1:0]   oBlue,
    output logic               oKey,
    output logic [COUNT_W-1:0] oKey_Count
);

    logic [NUM_WIN-1:0] match_s1;
    logic [NUM_WIN-1:0] win_en_s1;
    logic               invert_s1;
    logic               dval_s1;
    logic [RGB_W-1:0]   red_s1, green_s1, blue_s1;
    logic [RGB_W-1:0]   bg_r_s1, bg_g_s1, bg_b_s1;

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        keyer_window_cmp #(
            .DATA_W  (DATA_W),
            .WIN_IDX (w)
        ) u_win (
            .clk      (iCLK),
            .rst_n    (iRST_N),
            .cfg_we   (iCfg_WE),
            .cfg_win  (iCfg_Win),
            .cfg_sel  (iCfg_Sel),
            .cfg_data (iCfg_Data),
            .y        (iY),
            .cb       (iCb),
            .cr       (iCr),
            .match    (match_s1[w])
        );
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            win_en_s1 <= '0;
            invert_s1 <= 1'b0;
            dval_s1   <= 1'b0;
            red_s1    <= '0;
            green_s1  <= '0;
            blue_s1   <= '0;
            bg_r_s1   <= '0;
            bg_g_s1   <= '0;
            bg_b_s1   <= '0;
        end else begin
            win_en_s1 <= iWin_En;
            invert_s1 <= iInvert;
            dval_s1   <= iDVAL;
            red_s1    <= iRed;
            green_s1  <= iGreen;
            blue_s1   <= iBlue;
            bg_r_s1   <= iBg_R;
            bg_g_s1   <= iBg_G;
            bg_b_s1   <= iBg_B;
        end
    end

    // Invert is gated by "any window enabled" so a fully disabled keyer never keys.
    logic key_s1;
    assign key_s1 = ((|(match_s1 & win_en_s1)) ^ invert_s1) & (|win_en_s1);

    logic [RGB_W-1:0] mux_r, mux_g, mux_b;

    // NOTE: every output gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        mux_r = red_s1;
        mux_g = green_s1;
        mux_b = blue_s1;
        case (mode_e'(iMode))
            MODE_BG: if (key_s1) begin
                mux_r = bg_r_s1;
                mux_g = bg_g_s1;
                mux_b = bg_b_s1;
            end
            MODE_FILL: if (key_s1) begin
                mux_r = FILL_R;
                mux_g = FILL_G;
                mux_b = FILL_B;
            end
            MODE_MASK: begin
                mux_r = key_s1 ? '1 : '0;
                mux_g = key_s1 ? '1 : '0;
                mux_b = key_s1 ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oDVAL  <= 1'b0;
            oKey   <= 1'b0;
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else begin
            oDVAL  <= dval_s1;
            oKey   <= key_s1 & dval_s1;
            oRed   <= mux_r;
            oGreen <= mux_g;
            oBlue  <= mux_b;
        end
    end

    logic               vs_q;
    logic               vs_rise;
    logic [COUNT_W-1:0] run_count;
    logic [COUNT_W-1:0] count_next;

    // count_next already includes the keyed pixel on the output this cycle.
    assign count_next = (oDVAL && oKey && (run_count != '1)) ? run_count + COUNT_W'(1)
                                                             : run_count;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_q       <= 1'b0;
            vs_rise    <= 1'b0;
            run_count  <= '0;
            oKey_Count <= '0;
        end else begin
            vs_q    <= iVS;
            vs_rise <= iVS & ~vs_q;
            if (vs_rise) begin
                oKey_Count <= count_next;
                run_count  <= '0;
            end else begin
                run_count  <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_chroma_keyer.sv
// Directed-vector bench for ycbcr_chroma_keyer with hand-computed expectations.
module tb_ycbcr_chroma_keyer;
    import ycbcr_keyer_pkg::*;

    localparam logic [9:0] LIVE_R = 10'h123, LIVE_G = 10'h234, LIVE_B = 10'h345;
    localparam logic [9:0] BG_R   = 10'h0AA, BG_G   = 10'h155, BG_B   = 10'h2BB;
    localparam logic [29:0] LIVE = {LIVE_R, LIVE_G, LIVE_B};
    localparam logic [29:0] BG   = {BG_R, BG_G, BG_B};
    localparam logic [29:0] FILL = {10'h3FF, 10'h190, 10'h050};
    localparam logic [29:0] ONES = 30'h3FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_win, cfg_sel;
    logic [7:0]  cfg_data;
    logic [1:0]  win_en;
    logic        invert;
    logic [1:0]  mode;
    logic        vs, dval;
    logic [7:0]  y, cb, cr;
    logic        o_dval, o_key;
    logic [9:0]  o_r, o_g, o_b;
    logic [19:0] o_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ycbcr_chroma_keyer dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iCfg_WE    (cfg_we),
        .iCfg_Win   (cfg_win),
        .iCfg_Sel   (cfg_sel),
        .iCfg_Data  (cfg_data),
        .iWin_En    (win_en),
        .iInvert    (invert),
        .iMode      (mode),
        .iVS        (vs),
        .iDVAL      (dval),
        .iY         (y),
        .iCb        (cb),
        .iCr        (cr),
        .iRed       (LIVE_R),
        .iGreen     (LIVE_G),
        .iBlue      (LIVE_B),
        .iBg_R      (BG_R),
        .iBg_G      (BG_G),
        .iBg_B      (BG_B),
        .oDVAL      (o_dval),
        .oRed       (o_r),
        .oGreen     (o_g),
        .oBlue      (o_b),
        .oKey       (o_key),
        .oKey_Count (o_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] w, input logic [2:0] s, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_win = w; cfg_sel = s; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic program_win(input logic [2:0] w, input logic [7:0] ylo, yhi,
                               cblo, cbhi, crlo, crhi);
        cfg_write(w, SEL_Y_LO, ylo);   cfg_write(w, SEL_Y_HI, yhi);
        cfg_write(w, SEL_CB_LO, cblo); cfg_write(w, SEL_CB_HI, cbhi);
        cfg_write(w, SEL_CR_LO, crlo); cfg_write(w, SEL_CR_HI, crhi);
    endtask

    // One isolated pixel; outputs are read just after the second edge.
    task automatic send_pixel(input logic [7:0] py, pcb, pcr,
                              output logic [29:0] rgb, output logic k, output logic v);
        @(negedge clk);
        y = py; cb = pcb; cr = pcr; dval = 1'b1;
        @(negedge clk);
        dval = 1'b0;
        @(posedge clk); #1;
        rgb = {o_r, o_g, o_b}; k = o_key; v = o_dval;
    endtask

    task automatic check_px(input string tag, input logic [7:0] py, pcb, pcr,
                            input logic [29:0] exp_rgb, input logic exp_k);
        logic [29:0] rgb;
        logic        k, v;
        send_pixel(py, pcb, pcr, rgb, k, v);
        check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        check({tag, "_key"}, 32'(k), 32'(exp_k));
        check({tag, "_dval"}, 32'(v), 32'd1);
    endtask

    task automatic vs_pulse(input string tag, input logic [19:0] prev, input logic [19:0] exp);
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk); #1;
        check({tag, "_hold"}, 32'(o_count), 32'(prev));
        @(posedge clk); #1;
        check(tag, 32'(o_count), 32'(exp));
        @(negedge clk);
        vs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] rgb;
        logic        k, v;
        int          m3_bad;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_win = '0; cfg_sel = '0; cfg_data = '0;
        win_en = '0; invert = 1'b0; mode = MODE_BG; vs = 1'b0; dval = 1'b0;
        y = '0; cb = '0; cr = '0;
        repeat (3) @(negedge clk);
        check("rst_dval", 32'(o_dval), 32'd0);
        check("rst_key", 32'(o_key), 32'd0);
        check("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        rst_n = 1'b1;

        // Defaults, no window enabled: live pixel, two-cycle valid latency.
        @(negedge clk);
        y = 8'd80; cb = 8'd120; cr = 8'd200; dval = 1'b1;
        @(negedge clk);
        dval = 1'b0;
        check("lat_dval_1", 32'(o_dval), 32'd0);
        @(posedge clk); #1;
        check("lat_dval_2", 32'(o_dval), 32'd1);
        check("dis_rgb", 32'({o_r, o_g, o_b}), 32'(LIVE));
        check("dis_key", 32'(o_key), 32'd0);

        // Window 0 keyed to background, Cb upper edge inclusive.
        program_win(3'd0, 8'd16, 8'd235, 8'd100, 8'd140, 8'd100, 8'd140);
        win_en = 2'b01; mode = MODE_BG;
        check_px("bg_cb140", 8'd80, 8'd140, 8'd120, BG, 1'b1);
        check_px("bg_cb141", 8'd80, 8'd141, 8'd120, LIVE, 1'b0);

        // Inverted key with fill colour.
        invert = 1'b1; mode = MODE_FILL;
        check_px("inv_cb141", 8'd80, 8'd141, 8'd120, FILL, 1'b1);
        check_px("inv_cb120", 8'd80, 8'd120, 8'd120, LIVE, 1'b0);

        // Write of Cblo = 130 on the same edge as a Cb = 120 pixel: old bound applies.
        invert = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_win = 3'd0; cfg_sel = SEL_CB_LO; cfg_data = 8'd130;
        y = 8'd80; cb = 8'd120; cr = 8'd120; dval = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; dval = 1'b0;
        @(posedge clk); #1;
        check("wr_same_rgb", 32'({o_r, o_g, o_b}), 32'(FILL));
        check("wr_same_key", 32'(o_key), 32'd1);
        check_px("wr_next", 8'd80, 8'd120, 8'd120, LIVE, 1'b0);

        // Mask mode, lower-edge boundary, inverted window, ignored writes.
        mode = MODE_MASK;
        check_px("m3_cb130", 8'd80, 8'd130, 8'd120, ONES, 1'b1);
        check_px("m3_cb129", 8'd80, 8'd129, 8'd120, 30'd0, 1'b0);
        program_win(3'd1, 8'd200, 8'd100, 8'd0, 8'd255, 8'd0, 8'd255);
        win_en = 2'b10;
        check_px("lohi_y150", 8'd150, 8'd135, 8'd120, 30'd0, 1'b0);
        check_px("lohi_y200", 8'd200, 8'd135, 8'd120, 30'd0, 1'b0);
        win_en = 2'b11;
        check_px("both_en", 8'd150, 8'd135, 8'd120, ONES, 1'b1);
        win_en = 2'b01;
        cfg_write(3'd0, 3'd6, 8'd0);
        cfg_write(3'd0, 3'd7, 8'd0);
        cfg_write(3'd2, SEL_CB_LO, 8'd0);
        check_px("ign_cb129", 8'd80, 8'd129, 8'd120, 30'd0, 1'b0);
        check_px("ign_cb135", 8'd80, 8'd135, 8'd120, ONES, 1'b1);

        // Keyed so far: cb140, inv_cb141, wr_same, cb130, both_en, ign_cb135.
        vs_pulse("frame_a", 20'd0, 20'd6);

        // 100-pixel mask frame, first 37 keyed.
        m3_bad = 0;
        for (int i = 0; i < 100; i++) begin
            send_pixel(8'd80, (i < 37) ? 8'd135 : 8'd120, 8'd120, rgb, k, v);
            if (rgb !== ((i < 37) ? ONES : 30'd0) || k !== (i < 37) || v !== 1'b1)
                m3_bad++;
        end
        check("m3_frame_px", 32'(m3_bad), 32'd0);
        vs_pulse("frame_37", 20'd6, 20'd37);
        vs_pulse("frame_empty", 20'd37, 20'd0);

        // Back-to-back keyed pixels, then reset mid-frame.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            y = 8'd80; cb = 8'd135; cr = 8'd120; dval = 1'b1;
        end
        @(negedge clk);
        dval = 1'b0;
        repeat (3) @(negedge clk);
        vs_pulse("frame_50", 20'd0, 20'd50);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            y = 8'd80; cb = 8'd135; cr = 8'd120; dval = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dval", 32'(o_dval), 32'd0);
        check("mid_rst_key", 32'(o_key), 32'd0);
        check("mid_rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check("mid_rst_count", 32'(o_count), 32'd0);
        @(negedge clk);
        dval = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults restored: both windows match everything again.
        mode = MODE_FILL; win_en = 2'b01;
        check_px("def_w0", 8'd80, 8'd200, 8'd120, FILL, 1'b1);
        win_en = 2'b10;
        check_px("def_w1", 8'd150, 8'd135, 8'd120, FILL, 1'b1);
        vs_pulse("frame_post_rst", 20'd0, 20'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ycbcr_chroma_keyer.md
# ycbcr_chroma_keyer

Parametrised chroma-key compositor for the TV-in → VGA path. Compares each decoded YCbCr pixel against NUM_WIN programmable inclusive windows, then passes the live RGB pixel, substitutes a background pixel or constant fill, or emits a key mask. All thresholds are registered and written through a config port, not held in combinational latches. A per-frame keyed-pixel counter supports threshold tuning. Sits between the YCbCr→RGB converter/line buffers and the VGA controller RGB inputs.

## Interface
- DATA_W, 8: Y/Cb/Cr component width
- RGB_W, 10: RGB channel width
- NUM_WIN, 2: number of key windows (1..8)
- COUNT_W, 20: keyed-pixel counter width
- FILL_R/FILL_G/FILL_B, 10'h3FF/10'h190/10'h050: constant fill colour

- iCLK  in  1  pixel clock (TD_CLK27 domain); the only clock
- iRST_N  in  1  asynchronous, active-low reset
- iCfg_WE  in  1  config write strobe, one cycle
- iCfg_Win  in  3  target window index
- iCfg_Sel  in  3  0 Ylo, 1 Yhi, 2 Cblo, 3 Cbhi, 4 Crlo, 5 Crhi; 6/7 reserved
- iCfg_Data  in  DATA_W  bound value
- iWin_En  in  NUM_WIN  per-window enable
- iInvert  in  1  key = pixel outside all enabled windows
- iMode  in  2  0 pass, 1 background, 2 fill, 3 mask
- iVS  in  1  frame marker; rising edge closes a frame
- iDVAL  in  1  input pixel valid
- iY, iCb, iCr  in  DATA_W each  pixel components
- iRed, iGreen, iBlue  in  RGB_W each  live RGB of the same pixel
- iBg_R, iBg_G, iBg_B  in  RGB_W each  background pixel, aligned with iDVAL
- oDVAL  out  1  output valid
- oRed, oGreen, oBlue  out  RGB_W each  composited pixel
- oKey  out  1  key flag for the output pixel
- oKey_Count  out  COUNT_W  keyed pixels in the last complete frame

## Operation
- Bound registers reset to lo = 0, hi = all-ones for every window. Every window then matches everything, but has no effect until enabled.
- Write: on iCfg_WE, the bound selected by iCfg_Win and iCfg_Sel is loaded with iCfg_Data. A write with Sel 6/7 or Win ≥ NUM_WIN is ignored.
- Window match: lo ≤ v ≤ hi, unsigned and inclusive, on all three components. If lo > hi on any component, that window never matches.
- raw = OR over enabled matching windows. key = raw XOR iInvert. With iWin_En all zero, key = 0 regardless of iInvert.
- Output select:
  - key = 0: live RGB.
  - key = 1, mode 0: live RGB.
  - key = 1, mode 1: background.
  - key = 1, mode 2: FILL constants.
  - Mode 3 ignores live RGB: all-ones when key = 1, zero when key = 0.
- oKey carries key in every mode. oKey is 0 when oDVAL = 0.
- Counter: increments on each output cycle with oDVAL & oKey, and saturates at all-ones.
- On a registered iVS rising edge, oKey_Count takes the running count plus the same-cycle keyed pixel. The running count then restarts at 0.

## Timing
- Latency: 2 cycles, fully pipelined, one pixel per clock, no backpressure.
  - Stage 1 registers the compare results and the RGB/background data.
  - Stage 2 registers the mux output.
- A pixel with iDVAL = 0 still propagates. oDVAL is iDVAL delayed by 2; RGB is don't-care when oDVAL = 0.
- A config write at edge t affects pixels sampled at edge t+1 and later. The pixel sampled at edge t uses the old bound.
- iWin_En, iInvert and iMode are sampled with the pixel at stage 1 and stage 2 respectively. Changes are effective per pixel, with no frame alignment.
- iVS edge detect adds 1 cycle. oKey_Count updates 2 cycles after iVS rises.
- Reset state: all outputs are 0, the pipeline is cleared, bounds return to reset values, and counters are 0. Reset mid-frame discards the partial count.

## Structure
- Package ycbcr_keyer_pkg holds the Sel encodings, the Mode encodings (MODE_PASS/BG/FILL/MASK) and a bound-struct typedef {lo, hi} × 3.
- Sub-module keyer_window_cmp is instantiated NUM_WIN times. It holds one window's six bound registers and write decode, and outputs a registered match flag.
- The top level contains the OR/invert logic, the output mux, the pipeline and the counter.

## Test plan
- Reset only: all bounds at default, iWin_En = 0, mode 1, pixel Y/Cb/Cr = 80/120/200 → output = live RGB, oKey = 0, oDVAL 2 cycles after iDVAL.
- Window 0 programmed to Y 16..235, Cb 100..140, Cr 100..140, enabled, mode 1. Pixels Cb = 140 then Cb = 141 → first output is background with oKey = 1; second is live with oKey = 0.
- Same window with iInvert = 1, mode 2 → pixel Cb = 141 gives FILL 3FF/190/050; Cb = 120 passes live.
- Config write Cblo = 130 in the same cycle as a pixel with Cb = 120 → that pixel is keyed. The next pixel with Cb = 120 is not keyed.
- Mode 3: 100 valid pixels over a frame, 37 keyed; pulse iVS → oKey_Count = 37 two cycles later, and the next frame starts from 0. Window with lo > hi never matches. Write with Sel = 7 changes nothing.
- Reset: assert iRST_N low mid-frame after 50 keyed pixels → outputs and count go to 0 immediately. After release, the bounds are back at their defaults.
